// File: rtl/sa_result_serializer.sv
// Buffers systolic-array result vectors in a DEPTH-entry FIFO and drains them byte-wise to a UART; first byte 3 cycles after strobe.
// i_tx_done paces every byte; a strobe into a full FIFO is dropped and latches o_overflow. Optional framing: SA_SER_FRAME_EN.
module sa_result_serializer #(
   parameter int N_LANES   = 16,
   parameter int W_LANE    = 32,
   parameter int W_BYTE    = 8,
   parameter int DEPTH     = 4,
   parameter int MSB_FIRST = 0
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_vec_dv,
   input  logic [N_LANES*W_LANE-1:0]   i_vec,
   output logic                        o_vec_ready,
   output logic                        o_tx_dv,
   output logic [W_BYTE-1:0]           o_tx_byte,
   input  logic                        i_tx_done,
   output logic                        o_busy,
   output logic                        o_overflow
);
   localparam int VW  = N_LANES * W_LANE;
   localparam int BPL = (W_LANE + W_BYTE - 1) / W_BYTE;
   localparam int PW  = BPL * W_BYTE;
   localparam int AW  = $clog2(DEPTH);
   localparam int CW  = AW + 1;
   localparam int LW  = (N_LANES > 1) ? $clog2(N_LANES) : 1;
   localparam int BW  = (BPL > 1) ? $clog2(BPL) : 1;
   localparam logic [CW-1:0] FULL      = CW'(DEPTH);
   localparam logic [LW-1:0] LAST_LANE = LW'(N_LANES - 1);
   localparam logic [BW-1:0] LAST_BYTE = BW'(BPL - 1);

   typedef enum logic [2:0] {
      IDLE, LOAD, SEND, WAIT
`ifdef SA_SER_FRAME_EN
      , HDR, CSUM
`endif
   } state_t;

   state_t            state, state_n, from_st;
   logic [VW-1:0]     mem [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     count;
   logic              push, pop;
   logic [VW-1:0]     vec_q;
   logic [LW-1:0]     lane_idx;
   logic [BW-1:0]     byte_idx;
   logic [BW-1:0]     eff_idx;
   logic [W_LANE-1:0] lane_sel;
   logic [PW-1:0]     lane_pad;
   logic [W_BYTE-1:0] byte_sel, tx_hold, tx_byte;
   logic              tx_dv, last_byte;
`ifdef SA_SER_FRAME_EN
   logic [W_BYTE-1:0] csum_q;
`endif

   // A pop in the same cycle never frees room for a write into a full FIFO.
   assign push = i_vec_dv && (count != FULL);
   assign pop  = (state == LOAD);

   always_ff @(posedge i_clk) begin
      if (push)
         mem[wr_ptr] <= i_vec;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         o_overflow <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
         if (i_vec_dv && (count == FULL))
            o_overflow <= 1'b1;
      end
   end

   always_comb begin
      lane_sel = W_LANE'(vec_q >> (lane_idx * W_LANE));
      lane_pad = PW'(lane_sel);
      eff_idx  = (MSB_FIRST != 0) ? (LAST_BYTE - byte_idx) : byte_idx;
      byte_sel = W_BYTE'(lane_pad >> (eff_idx * W_BYTE));
   end

   assign last_byte = (lane_idx == LAST_LANE) && (byte_idx == LAST_BYTE);

   always_comb begin
      state_n = state;
      case (state)
         IDLE: if (count != '0) state_n = LOAD;
`ifdef SA_SER_FRAME_EN
         LOAD: state_n = HDR;
         HDR:  state_n = WAIT;
         CSUM: state_n = WAIT;
`else
         LOAD: state_n = SEND;
`endif
         SEND: state_n = WAIT;
         WAIT: begin
            if (i_tx_done) begin
`ifdef SA_SER_FRAME_EN
               if (from_st == HDR)
                  state_n = SEND;
               else if (from_st == CSUM)
                  state_n = (count != '0) ? LOAD : IDLE;
               else if (last_byte)
                  state_n = CSUM;
               else
                  state_n = SEND;
`else
               if (last_byte)
                  state_n = (count != '0) ? LOAD : IDLE;
               else
                  state_n = SEND;
`endif
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      tx_dv   = 1'b0;
      tx_byte = tx_hold;
      case (state)
         SEND: begin
            tx_dv   = 1'b1;
            tx_byte = byte_sel;
         end
`ifdef SA_SER_FRAME_EN
         HDR: begin
            tx_dv   = 1'b1;
            tx_byte = W_BYTE'(8'hA5);
         end
         CSUM: begin
            tx_dv   = 1'b1;
            tx_byte = csum_q;
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state    <= IDLE;
         from_st  <= IDLE;
         vec_q    <= '0;
         lane_idx <= '0;
         byte_idx <= '0;
         tx_hold  <= '0;
`ifdef SA_SER_FRAME_EN
         csum_q   <= '0;
`endif
      end else begin
         state <= state_n;
         if (state == LOAD) begin
            vec_q    <= mem[rd_ptr];
            lane_idx <= '0;
            byte_idx <= '0;
`ifdef SA_SER_FRAME_EN
            csum_q   <= '0;
`endif
         end
         if (tx_dv) begin
            tx_hold <= tx_byte;
            from_st <= state;
         end
`ifdef SA_SER_FRAME_EN
         if (state == SEND)
            csum_q <= csum_q ^ byte_sel;
`endif
         // Indices only move after a payload byte completes, never after header or checksum.
         if ((state == WAIT) && i_tx_done && (from_st == SEND)) begin
            if (byte_idx == LAST_BYTE) begin
               byte_idx <= '0;
               lane_idx <= (lane_idx == LAST_LANE) ? '0 : lane_idx + 1'b1;
            end else begin
               byte_idx <= byte_idx + 1'b1;
            end
         end
      end
   end

   assign o_tx_dv     = tx_dv;
   assign o_tx_byte   = tx_byte;
   assign o_vec_ready = (count != FULL);
   assign o_busy      = (state != IDLE) || (count != '0);

endmodule

// File: tb/tb_sa_result_serializer.sv
// Directed bench: three serializer configurations (LSB-first, MSB-first, padded 12-bit lane) sharing one clock and reset.
module tb_sa_result_serializer;
`ifdef SA_SER_FRAME_EN
   localparam bit FR = 1'b1;
`else
   localparam bit FR = 1'b0;
`endif
   localparam int BPV0 = FR ? 10 : 8;
   localparam int BPV2 = FR ? 4 : 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic vdv0, rdy0, txdv0, done0, busy0, ovf0;
   logic [63:0] vec0;
   logic [7:0]  txb0;
   logic vdv1, rdy1, txdv1, done1, busy1, ovf1;
   logic [63:0] vec1;
   logic [7:0]  txb1;
   logic vdv2, rdy2, txdv2, done2, busy2, ovf2;
   logic [11:0] vec2;
   logic [7:0]  txb2;

   int total = 0;
   int bad   = 0;
   logic [7:0] log0[$], log1[$], log2[$], expq[$];

   sa_result_serializer #(.N_LANES(2), .W_LANE(32), .W_BYTE(8), .DEPTH(4), .MSB_FIRST(0)) u0 (
      .i_clk(clk), .i_rst(rst), .i_vec_dv(vdv0), .i_vec(vec0), .o_vec_ready(rdy0),
      .o_tx_dv(txdv0), .o_tx_byte(txb0), .i_tx_done(done0), .o_busy(busy0), .o_overflow(ovf0));
   sa_result_serializer #(.N_LANES(2), .W_LANE(32), .W_BYTE(8), .DEPTH(4), .MSB_FIRST(1)) u1 (
      .i_clk(clk), .i_rst(rst), .i_vec_dv(vdv1), .i_vec(vec1), .o_vec_ready(rdy1),
      .o_tx_dv(txdv1), .o_tx_byte(txb1), .i_tx_done(done1), .o_busy(busy1), .o_overflow(ovf1));
   sa_result_serializer #(.N_LANES(1), .W_LANE(12), .W_BYTE(8), .DEPTH(4), .MSB_FIRST(0)) u2 (
      .i_clk(clk), .i_rst(rst), .i_vec_dv(vdv2), .i_vec(vec2), .o_vec_ready(rdy2),
      .o_tx_dv(txdv2), .o_tx_byte(txb2), .i_tx_done(done2), .o_busy(busy2), .o_overflow(ovf2));

   always @(negedge clk) begin
      if (txdv0 === 1'b1) log0.push_back(txb0);
      if (txdv1 === 1'b1) log1.push_back(txb1);
      if (txdv2 === 1'b1) log2.push_back(txb2);
   end

   function automatic logic cur_dv(input int which);
      case (which)
         0:       return txdv0;
         1:       return txdv1;
         default: return txdv2;
      endcase
   endfunction

   task automatic set_done(input int which, input logic v);
      case (which)
         0:       done0 = v;
         1:       done1 = v;
         default: done2 = v;
      endcase
   endtask

   // Answers each byte with i_tx_done 4 cycles after o_tx_dv. Starts one negedge after the strobe,
   // so the first byte should be seen after w+1 == first_lat cycles. Inside a vector the next byte
   // follows done by one cycle (w==0); across vectors LOAD adds one more (w==1).
   task automatic rx(input int which, input int nb, input int first_lat, input int bpv, input int off);
      int w;
      int exp_w;
      for (int i = 0; i < nb; i++) begin
         w = 0;
         while (cur_dv(which) !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
         end
         if (w >= 200) begin
            total++; bad++;
            $display("FAIL rx_timeout dut%0d byte %0d: no o_tx_dv seen, required one", which, i);
            return;
         end
         total++;
         if (i == 0 && first_lat >= 0) begin
            if (w + 1 !== first_lat) begin
               bad++;
               $display("FAIL first_latency dut%0d: got %0d cycles, required %0d", which, w + 1, first_lat);
            end
         end else begin
            exp_w = (((i + off) % bpv) == 0) ? 1 : 0;
            if (w !== exp_w) begin
               bad++;
               $display("FAIL pacing dut%0d byte %0d: gap %0d, required %0d", which, i, w, exp_w);
            end
         end
         repeat (4) @(negedge clk);
         set_done(which, 1'b1);
         @(negedge clk);
         set_done(which, 1'b0);
      end
   endtask

   task automatic exp_append(input logic [7:0] pay[$]);
      logic [7:0] x;
      x = 8'h00;
      if (FR) expq.push_back(8'hA5);
      foreach (pay[i]) begin
         expq.push_back(pay[i]);
         x = x ^ pay[i];
      end
      if (FR) expq.push_back(x);
   endtask

   task automatic check_log(input int which, input string name);
      logic [7:0] got[$];
      case (which)
         0:       got = log0;
         1:       got = log1;
         default: got = log2;
      endcase
      total++;
      if (got.size() !== expq.size()) begin
         bad++;
         $display("FAIL %s_count: got %0d bytes, required %0d", name, got.size(), expq.size());
      end
      for (int i = 0; i < expq.size(); i++) begin
         total++;
         if (i >= got.size()) begin
            bad++;
            $display("FAIL %s_byte%0d: missing, required %h", name, i, expq[i]);
         end else if (got[i] !== expq[i]) begin
            bad++;
            $display("FAIL %s_byte%0d: got %h, required %h", name, i, got[i], expq[i]);
         end
      end
   endtask

   task automatic check_bit(input string name, input logic got, input logic req);
      total++;
      if (got !== req) begin
         bad++;
         $display("FAIL %s: got %b, required %b", name, got, req);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_bit("rst_tx_dv", txdv0, 1'b0);
      total++;
      if (txb0 !== 8'h00) begin bad++; $display("FAIL rst_tx_byte: got %h, required 00", txb0); end
      check_bit("rst_overflow", ovf0, 1'b0);
      check_bit("rst_busy", busy0, 1'b0);
      check_bit("rst_ready", rdy0, 1'b1);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [7:0] p[$];
      log0.delete(); expq.delete();
      vec0 = 64'h1122334455667788; vdv0 = 1'b1;
      @(negedge clk); vdv0 = 1'b0;
      rx(0, BPV0, 3, BPV0, 0);
      check_bit("basic_busy_after", busy0, 1'b0);
      p = {8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
      exp_append(p);
      check_log(0, "basic");
   endtask

   task automatic test_msb_first();
      logic [7:0] p[$];
      log1.delete(); expq.delete();
      vec1 = 64'h1122334455667788; vdv1 = 1'b1;
      @(negedge clk); vdv1 = 1'b0;
      rx(1, BPV0, 3, BPV0, 0);
      check_bit("msb_busy_after", busy1, 1'b0);
      p = {8'h55, 8'h66, 8'h77, 8'h88, 8'h11, 8'h22, 8'h33, 8'h44};
      exp_append(p);
      check_log(1, "msb");
   endtask

   task automatic test_pad();
      logic [7:0] p[$];
      log2.delete(); expq.delete();
      vec2 = 12'hABC; vdv2 = 1'b1;
      @(negedge clk); vdv2 = 1'b0;
      rx(2, BPV2, 3, BPV2, 0);
      check_bit("pad_busy_after", busy2, 1'b0);
      p = {8'hBC, 8'h0A};
      exp_append(p);
      check_log(2, "pad");
   endtask

   task automatic test_overflow();
      logic [7:0] p[$];
      logic [63:0] v;
      log0.delete(); expq.delete();
      for (int k = 1; k <= 6; k++) begin
         v = '0;
         for (int j = 0; j < 8; j++) v[j*8 +: 8] = 8'(k * 16 + j);
         vec0 = v; vdv0 = 1'b1;
         @(negedge clk);
      end
      vdv0 = 1'b0;
      check_bit("ovf_ready_low", rdy0, 1'b0);
      check_bit("ovf_flag_set", ovf0, 1'b1);
      repeat (5) @(negedge clk);
      check_bit("ovf_ready_held_low", rdy0, 1'b0);
      total++;
      if (log0.size() !== 1) begin
         bad++;
         $display("FAIL ovf_stalled_bytes: got %0d bytes, required 1", log0.size());
      end
      done0 = 1'b1;
      @(negedge clk);
      done0 = 1'b0;
      rx(0, 5 * BPV0 - 1, -1, BPV0, 1);
      check_bit("ovf_busy_after", busy0, 1'b0);
      check_bit("ovf_ready_back", rdy0, 1'b1);
      check_bit("ovf_flag_sticky", ovf0, 1'b1);
      for (int k = 1; k <= 5; k++) begin
         p.delete();
         for (int j = 0; j < 8; j++) p.push_back(8'(k * 16 + j));
         exp_append(p);
      end
      check_log(0, "ovf");
   endtask

   task automatic test_reset_mid();
      logic [7:0] p[$];
      check_bit("mid_ovf_before_rst", ovf0, 1'b1);
      vec0 = 64'hCAFEBABEDEADBEEF; vdv0 = 1'b1;
      @(negedge clk); vdv0 = 1'b0;
      rx(0, 2, 3, BPV0, 0);
      @(negedge clk);
      @(negedge clk);
      check_bit("mid_busy_in_wait", busy0, 1'b1);
      rst = 1'b1;
      #1;
      check_bit("mid_rst_tx_dv", txdv0, 1'b0);
      total++;
      if (txb0 !== 8'h00) begin bad++; $display("FAIL mid_rst_tx_byte: got %h, required 00", txb0); end
      check_bit("mid_rst_busy", busy0, 1'b0);
      check_bit("mid_rst_ready", rdy0, 1'b1);
      check_bit("mid_rst_overflow", ovf0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      log0.delete();
      done0 = 1'b1;
      @(negedge clk);
      done0 = 1'b0;
      repeat (6) @(negedge clk);
      total++;
      if (log0.size() !== 0) begin
         bad++;
         $display("FAIL stray_done: got %0d bytes, required 0", log0.size());
      end
      expq.delete();
      vec0 = 64'h1122334455667788; vdv0 = 1'b1;
      @(negedge clk); vdv0 = 1'b0;
      rx(0, BPV0, 3, BPV0, 0);
      p = {8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
      exp_append(p);
      check_log(0, "after_rst");
   endtask

`ifdef SA_SER_FRAME_EN
   task automatic test_frame();
      log0.delete();
      expq = {8'hA5, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h08};
      vec0 = 64'h0102030405060708; vdv0 = 1'b1;
      @(negedge clk); vdv0 = 1'b0;
      rx(0, 10, 3, 10, 0);
      check_log(0, "frame");
   endtask
`endif

   initial begin
      rst = 1'b1;
      vdv0 = 1'b0; vec0 = '0; done0 = 1'b0;
      vdv1 = 1'b0; vec1 = '0; done1 = 1'b0;
      vdv2 = 1'b0; vec2 = '0; done2 = 1'b0;
      test_reset();
      test_basic();
      test_msb_first();
      test_pad();
      test_overflow();
      test_reset_mid();
`ifdef SA_SER_FRAME_EN
      test_frame();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
